// File: rtl/serial_mag_comparator_pkg.sv
// Shared types and defaults for the bit-serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_t;

  localparam int unsigned CMP_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/comparator.sv
// 1-bit cascade magnitude cell: e is the "all higher bits equal" enable.
module comparator (
  output logic gtr,
  output logic eq,
  output logic lt,
  input  logic A,
  input  logic B,
  input  logic e
);

  assign gtr = e &  A & ~B;
  assign lt  = e & ~A &  B;
  assign eq  = e & ~(A ^ B);

endmodule

// File: rtl/serial_mag_comparator.sv
// MSB-first bit-serial magnitude comparator driving a single comparator cell.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = CMP_DEFAULT_WIDTH,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             gtr,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned CW = $clog2(WIDTH);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eq_acc_q, eq_acc_d;
  logic             gt_acc_q, gt_acc_d;
  logic             lt_acc_q, lt_acc_d;
  logic             gtr_q, gtr_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic cell_gtr, cell_eq, cell_lt;

  comparator u_cell (
    .gtr (cell_gtr),
    .eq  (cell_eq),
    .lt  (cell_lt),
    .A   (sa_q[WIDTH-1]),
    .B   (sb_q[WIDTH-1]),
    .e   (eq_acc_q)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    eq_acc_d = eq_acc_q;
    gt_acc_d = gt_acc_q;
    lt_acc_d = lt_acc_q;
    gtr_d    = gtr_q;
    eq_d     = eq_q;
    lt_d     = lt_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          sa_d     = a_in;
          sb_d     = b_in;
          cnt_d    = CW'(WIDTH - 1);
          eq_acc_d = 1'b1;
          gt_acc_d = 1'b0;
          lt_acc_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        gt_acc_d = gt_acc_q | cell_gtr;
        lt_acc_d = lt_acc_q | cell_lt;
        eq_acc_d = cell_eq;
        sa_d     = {sa_q[WIDTH-2:0], 1'b0};
        sb_d     = {sb_q[WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q - CW'(1);
        // Results are published on the exit edge so they are valid while done is high.
        if (cnt_q == '0 || (EARLY_EXIT && !cell_eq)) begin
          state_d = DONE;
          gtr_d   = gt_acc_q | cell_gtr;
          eq_d    = cell_eq;
          lt_d    = lt_acc_q | cell_lt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      eq_acc_q <= 1'b0;
      gt_acc_q <= 1'b0;
      lt_acc_q <= 1'b0;
      gtr_q    <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      eq_acc_q <= eq_acc_d;
      gt_acc_q <= gt_acc_d;
      lt_acc_q <= lt_acc_d;
      gtr_q    <= gtr_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign gtr  = gtr_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: one early-exit and one full-run instance.
module tb_serial_mag_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start0;
  logic [7:0] a_in, b_in;
  logic       busy1, done1, gtr1, eq1, lt1;
  logic       busy0, done0, gtr0, eq0, lt0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a_in), .b_in(b_in),
    .busy(busy1), .done(done1), .gtr(gtr1), .eq(eq1), .lt(lt1)
  );

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_in(a_in), .b_in(b_in),
    .busy(busy0), .done(done0), .gtr(gtr0), .eq(eq0), .lt(lt0)
  );

  // {busy, done, gtr, eq, lt}
  function automatic logic [4:0] outs(input int sel);
    if (sel == 1) return {busy1, done1, gtr1, eq1, lt1};
    else          return {busy0, done0, gtr0, eq0, lt0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (plus one if hold).
  task automatic run(input int sel, input logic [7:0] a, input logic [7:0] b,
                     input int exp_edges, input logic [2:0] exp_res,
                     input bit hold, input string tag);
    logic [4:0] o;
    int n;
    a_in = a;
    b_in = b;
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    step();
    start1 = 1'b0;
    start0 = 1'b0;
    o = outs(sel);
    check({tag, "_accept_busy_done"}, {30'd0, o[4:3]}, 32'b10);
    n = 1;
    do begin
      step();
      n++;
      o = outs(sel);
    end while (!o[3] && n < 40);
    check({tag, "_latency"}, n, exp_edges);
    check({tag, "_busy_in_done"}, {31'd0, o[4]}, 32'd0);
    check({tag, "_result"}, {29'd0, o[2:0]}, {29'd0, exp_res});
    if (hold) begin
      step();
      o = outs(sel);
      check({tag, "_done_pulse"}, {30'd0, o[4:3]}, 32'd0);
      check({tag, "_hold"}, {29'd0, o[2:0]}, {29'd0, exp_res});
    end
  endtask

  initial begin
    logic [4:0] o;
    int n;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start0 = 1'b0;
    a_in   = '0;
    b_in   = '0;
    #12;
    check("reset_ee",   {27'd0, outs(1)}, 32'd0);
    check("reset_full", {27'd0, outs(0)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1, 8'hA5, 8'hA5, 9, 3'b010, 1'b1, "eq_a5");
    run(1, 8'h80, 8'h7F, 2, 3'b100, 1'b1, "ee_msb");
    run(1, 8'h12, 8'h13, 9, 3'b001, 1'b1, "lsb_mismatch");
    run(0, 8'h80, 8'h7F, 9, 3'b100, 1'b1, "noee_msb");
    run(1, 8'h3C, 8'h5A, 3, 3'b001, 1'b1, "ee_pos1");

    // Mid-SHIFT start is ignored; previous result held while busy.
    a_in   = 8'h34;
    b_in   = 8'h34;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    o = outs(1);
    check("hs_busy", {31'd0, o[4]}, 32'd1);
    check("hs_hold_during_busy", {29'd0, o[2:0]}, 32'b001);
    step();
    step();
    a_in   = 8'hFF;
    b_in   = 8'h00;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    a_in   = 8'h00;
    b_in   = 8'hFF;
    o = outs(1);
    check("hs_mid_start_busy_done", {30'd0, o[4:3]}, 32'b10);
    n = 4;
    do begin
      step();
      n++;
      o = outs(1);
    end while (!o[3] && n < 40);
    check("hs_latency", n, 9);
    check("hs_result", {29'd0, o[2:0]}, 32'b010);

    // Back-to-back start in the DONE cycle.
    a_in   = 8'h01;
    b_in   = 8'h02;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    o = outs(1);
    check("b2b_busy_done", {30'd0, o[4:3]}, 32'b10);
    check("b2b_hold", {29'd0, o[2:0]}, 32'b010);
    n = 1;
    do begin
      step();
      n++;
      o = outs(1);
    end while (!o[3] && n < 40);
    check("b2b_latency", n, 8);
    check("b2b_result", {29'd0, o[2:0]}, 32'b001);
    step();

    // Asynchronous reset in the middle of a compare.
    a_in   = 8'h12;
    b_in   = 8'h13;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    @(posedge clk);
    #2;
    check("pre_reset_busy", {31'd0, busy1}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ee",   {27'd0, outs(1)}, 32'd0);
    check("async_reset_full", {27'd0, outs(0)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("idle_after_reset", {27'd0, outs(1)}, 32'd0);
    run(1, 8'hFF, 8'h00, 2, 3'b100, 1'b1, "post_reset");
    run(0, 8'h12, 8'h13, 9, 3'b001, 1'b0, "noee_lsb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
